byte_serial_add_ctrl: RTL

Sequencer directly upstream of the registered 8-bit adder stage (`ina`/`inb`/`c_in` → `SUM`/`c_out`). It accepts a wide operand pair over a valid/ready handshake and feeds the adder one byte per slot, LSB first, chaining `c_out` back into `c_in`. It collects the returned bytes into a wide result and presents it downstream with its own valid/ready handshake. This turns the byte-wide adder into an N-byte adder without changing the adder itself.

---
 rtl/add_ctrl_pkg.sv | 24 ++
 rtl/byte_serial_add_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/add_ctrl_pkg.sv
// rtl/add_ctrl_pkg.sv - shared state type, byte width and clog2 helper for the byte-serial add sequencer
package add_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int BYTE_W = 8;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/byte_serial_add_ctrl.sv
// rtl/byte_serial_add_ctrl.sv - drives a byte-wide adder LSB first to build an N-byte add; ADD_CTRL_OVF_EN adds out_ovf
module byte_serial_add_ctrl
   import add_ctrl_pkg::*;
#(
   parameter int NBYTES  = 4,
   parameter int ADD_LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [BYTE_W*NBYTES-1:0]   in_a,
   input  logic [BYTE_W*NBYTES-1:0]   in_b,
   input  logic                       in_cin,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [BYTE_W*NBYTES-1:0]   out_sum,
   output logic                       out_cout,
   output logic [BYTE_W-1:0]          add_a,
   output logic [BYTE_W-1:0]          add_b,
   output logic                       add_cin,
   input  logic [BYTE_W-1:0]          add_sum,
   input  logic                       add_cout
`ifdef ADD_CTRL_OVF_EN
   ,
   output logic                       out_ovf
`endif
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int SW = (clog2(ADD_LAT + 1) > 0) ? clog2(ADD_LAT + 1) : 1;
   localparam int IW = (clog2(NBYTES) > 0) ? clog2(NBYTES) : 1;
   localparam logic [SW-1:0] SLOT_END = SW'(ADD_LAT);
   localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

   state_t          state;
   logic [SW-1:0]   slot;
   logic [IW-1:0]   idx;
   // Operands shifted right one byte per slot so the next byte is always at [7:0].
   logic [W-1:0]    a_sh;
   logic [W-1:0]    b_sh;
`ifdef ADD_CTRL_OVF_EN
   logic            a_msb;
   logic            b_msb;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         slot      <= '0;
         idx       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
         add_cin   <= 1'b0;
`ifdef ADD_CTRL_OVF_EN
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         out_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= in_a >> BYTE_W;
                  b_sh     <= in_b >> BYTE_W;
                  add_a    <= in_a[BYTE_W-1:0];
                  add_b    <= in_b[BYTE_W-1:0];
                  add_cin  <= in_cin;
                  idx      <= '0;
                  slot     <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
`ifdef ADD_CTRL_OVF_EN
                  a_msb    <= in_a[W-1];
                  b_msb    <= in_b[W-1];
`endif
               end
            end
            RUN: begin
               if (slot == SLOT_END) begin
                  slot    <= '0;
                  // Result fills from the top so byte i lands at its place after NBYTES slots.
                  out_sum <= (out_sum >> BYTE_W) | (W'(add_sum) << (W - BYTE_W));
                  if (idx == IDX_LAST) begin
                     out_cout  <= add_cout;
                     out_valid <= 1'b1;
                     add_a     <= '0;
                     add_b     <= '0;
                     add_cin   <= 1'b0;
                     state     <= DONE;
`ifdef ADD_CTRL_OVF_EN
                     out_ovf   <= (a_msb == b_msb) && (add_sum[BYTE_W-1] != a_msb);
`endif
                  end else begin
                     idx     <= idx + IW'(1);
                     add_a   <= a_sh[BYTE_W-1:0];
                     add_b   <= b_sh[BYTE_W-1:0];
                     add_cin <= add_cout;
                     a_sh    <= a_sh >> BYTE_W;
                     b_sh    <= b_sh >> BYTE_W;
                  end
               end else begin
                  slot <= slot + SW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
